// File: rtl/snoop_bus_ctrl_pkg.sv
// snoop_bus_ctrl_pkg: shared types and constants for the snooping bus controller.
package snoop_bus_ctrl_pkg;
    localparam int NUM_CPUS    = 4;
    localparam int TIMEOUT_CYC = 64;

    typedef enum logic [1:0] {
        BUS_RD   = 2'd0,
        BUS_RDX  = 2'd1,
        BUS_UPGR = 2'd2
    } bus_cmd_t;

    typedef enum logic [2:0] {IDLE, SNOOP, MEM_WB, MEM_RD, RESP} bus_state_t;

    function automatic logic [NUM_CPUS-1:0] lowest_bit(input logic [NUM_CPUS-1:0] v);
        return v & (-v);
    endfunction
endpackage

// File: rtl/snoop_bus_ctrl_collector.sv
// snoop_collector: gathers snoop acks, shared/dirty replies and the dirty owner's line.
module snoop_collector
    import snoop_bus_ctrl_pkg::*;
#(
    parameter int LINE_W = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       en,
    input  logic [NUM_CPUS-1:0]        src,
    input  logic [NUM_CPUS-1:0]        ack,
    input  logic [NUM_CPUS-1:0]        shared,
    input  logic [NUM_CPUS-1:0]        dirty,
    input  logic [NUM_CPUS*LINE_W-1:0] data,
    output logic                       done,
    output logic                       any_shared,
    output logic                       any_dirty,
    output logic [LINE_W-1:0]          owner_data
);
    logic [NUM_CPUS-1:0] mask, sh, dt, fresh, mask_nxt, sh_nxt, dt_nxt, own;
    logic [LINE_W-1:0]   held, mux;

    // Replies are only trusted in the cycle a cache's first ack arrives.
    always_comb begin
        fresh    = en ? ack & ~src & ~mask : '0;
        mask_nxt = mask | fresh;
        sh_nxt   = sh | (fresh & shared);
        dt_nxt   = dt | (fresh & dirty);
        own      = lowest_bit(fresh & dirty);
        mux      = '0;
        for (int i = 0; i < NUM_CPUS; i++)
            if (own[i]) mux = data[i*LINE_W +: LINE_W];
    end

    assign done       = mask_nxt == ~src;
    assign any_shared = |sh_nxt;
    assign any_dirty  = |dt_nxt;
    assign owner_data = |dt ? held : mux;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            mask <= '0;
            sh   <= '0;
            dt   <= '0;
            held <= '0;
        end else if (clr) begin
            mask <= '0;
            sh   <= '0;
            dt   <= '0;
            held <= '0;
        end else begin
            if (en) assert ($onehot0(dt_nxt));
            mask <= mask_nxt;
            sh   <= sh_nxt;
            dt   <= dt_nxt;
            if (~|dt && |own) held <= mux;
        end
endmodule

// File: rtl/snoop_bus_ctrl.sv
// snoop_bus_ctrl: serialises granted coherence transactions through snoop, memory and response.
// Optional snoop watchdog enabled by defining SNOOP_TIMEOUT_EN.
module snoop_bus_ctrl
    import snoop_bus_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CPUS-1:0]        gnt,
    input  logic [NUM_CPUS*2-1:0]      req_cmd,
    input  logic [NUM_CPUS*ADDR_W-1:0] req_addr,
    output logic                       bus_busy,
    output logic                       snoop_valid,
    output logic [1:0]                 snoop_cmd,
    output logic [ADDR_W-1:0]          snoop_addr,
    output logic [NUM_CPUS-1:0]        snoop_src,
    input  logic [NUM_CPUS-1:0]        snoop_ack,
    input  logic [NUM_CPUS-1:0]        snoop_shared,
    input  logic [NUM_CPUS-1:0]        snoop_dirty,
    input  logic [NUM_CPUS*LINE_W-1:0] snoop_data,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [LINE_W-1:0]          mem_wdata,
    input  logic                       mem_ready,
    input  logic [LINE_W-1:0]          mem_rdata,
    output logic [NUM_CPUS-1:0]        resp_valid,
    output logic                       resp_shared,
    output logic [LINE_W-1:0]          resp_data,
    output logic                       err_timeout
);
    bus_state_t          state;
    bus_cmd_t            cmd, cmd_sel;
    logic [NUM_CPUS-1:0] src, sel;
    logic [ADDR_W-1:0]   addr, addr_sel;
    logic [LINE_W-1:0]   data, owner_data;
    logic                done, timed, fin, any_shared, any_dirty, hit;

    always_comb begin
        sel      = lowest_bit(gnt);
        cmd_sel  = BUS_RD;
        addr_sel = '0;
        for (int i = 0; i < NUM_CPUS; i++)
            if (sel[i]) begin
                cmd_sel  = bus_cmd_t'(req_cmd[i*2 +: 2]);
                addr_sel = req_addr[i*ADDR_W +: ADDR_W];
            end
    end

    snoop_collector #(.LINE_W(LINE_W)) u_collector (
        .clk        (clk),
        .rst        (rst),
        .clr        (state == IDLE),
        .en         (state == SNOOP),
        .src        (src),
        .ack        (snoop_ack),
        .shared     (snoop_shared),
        .dirty      (snoop_dirty),
        .data       (snoop_data),
        .done       (done),
        .any_shared (any_shared),
        .any_dirty  (any_dirty),
        .owner_data (owner_data)
    );

`ifdef SNOOP_TIMEOUT_EN
    localparam int CW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
    logic [CW-1:0] cnt;
    assign timed = state == SNOOP && !done && cnt == CW'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cnt         <= '0;
            err_timeout <= 1'b0;
        end else begin
            cnt         <= (state == SNOOP && !fin) ? cnt + CW'(1) : '0;
            err_timeout <= timed;
        end
`else
    assign timed       = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign fin        = done | timed;
    assign snoop_src  = src;
    assign snoop_cmd  = cmd;
    assign snoop_addr = addr;
    assign mem_addr   = addr;
    assign mem_wdata  = data;
    assign resp_data  = data;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state       <= IDLE;
            src         <= '0;
            cmd         <= BUS_RD;
            addr        <= '0;
            data        <= '0;
            hit         <= 1'b0;
            bus_busy    <= 1'b0;
            snoop_valid <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            resp_valid  <= '0;
            resp_shared <= 1'b0;
        end else begin
            resp_valid <= '0;
            case (state)
                IDLE: begin
                    assert ($onehot0(gnt));
                    if (|gnt) begin
                        src         <= sel;
                        cmd         <= cmd_sel;
                        addr        <= addr_sel;
                        data        <= '0;
                        bus_busy    <= 1'b1;
                        snoop_valid <= 1'b1;
                        state       <= SNOOP;
                    end
                end
                SNOOP: if (fin) begin
                    snoop_valid <= 1'b0;
                    hit         <= any_shared | any_dirty;
                    if (cmd == BUS_UPGR) begin
                        resp_valid  <= src;
                        resp_shared <= 1'b0;
                        state       <= RESP;
                    end else begin
                        mem_req <= 1'b1;
                        mem_we  <= any_dirty;
                        if (any_dirty) data <= owner_data;
                        state   <= any_dirty ? MEM_WB : MEM_RD;
                    end
                end
                MEM_WB, MEM_RD: if (mem_ready) begin
                    mem_req     <= 1'b0;
                    mem_we      <= 1'b0;
                    if (state == MEM_RD) data <= mem_rdata;
                    resp_valid  <= src;
                    resp_shared <= cmd == BUS_RD && hit;
                    state       <= RESP;
                end
                RESP: begin
                    bus_busy    <= 1'b0;
                    resp_shared <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// tb_snoop_bus_ctrl: directed and randomized transactions against a per-transaction outcome model.
module tb_snoop_bus_ctrl;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int LW = 256;
`ifdef SNOOP_TIMEOUT_EN
    localparam int TO = 64;
`else
    localparam int TO = 1 << 30;
`endif

    logic            clk = 1'b0, rst = 1'b0;
    logic [N-1:0]    gnt = '0, snoop_ack = '0, snoop_shared = '0, snoop_dirty = '0;
    logic [N*2-1:0]  req_cmd = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*LW-1:0] snoop_data = '0;
    logic            mem_ready = 1'b0;
    logic [LW-1:0]   mem_rdata = '0;
    logic            bus_busy, snoop_valid, mem_req, mem_we, resp_shared, err_timeout;
    logic [1:0]      snoop_cmd;
    logic [AW-1:0]   snoop_addr, mem_addr;
    logic [N-1:0]    snoop_src, resp_valid;
    logic [LW-1:0]   mem_wdata, resp_data;

    int            tests = 0, fails = 0;
    int            dly[N];
    int            mlat;
    logic [N-1:0]  shr, drt;
    logic [LW-1:0] dat[N];
    logic [LW-1:0] mdat;

    snoop_bus_ctrl dut (
        .clk(clk), .rst(rst), .gnt(gnt), .req_cmd(req_cmd), .req_addr(req_addr),
        .bus_busy(bus_busy), .snoop_valid(snoop_valid), .snoop_cmd(snoop_cmd),
        .snoop_addr(snoop_addr), .snoop_src(snoop_src), .snoop_ack(snoop_ack),
        .snoop_shared(snoop_shared), .snoop_dirty(snoop_dirty), .snoop_data(snoop_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .resp_valid(resp_valid),
        .resp_shared(resp_shared), .resp_data(resp_data), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [N-1:0] rnd_gnt();
        return $urandom_range(0, 1) == 1 ? N'(1) << $urandom_range(0, N - 1) : '0;
    endfunction

    task automatic defaults;
        foreach (dly[i]) begin
            dly[i] = 0;
            dat[i] = rnd_line();
        end
        shr  = '0;
        drt  = '0;
        mdat = rnd_line();
        mlat = 0;
    endtask

    // Drives one granted transaction acting as the caches and memory, checking the outcome.
    task automatic run_txn(input int r, input logic [1:0] c, input logic [AW-1:0] a);
        logic [N-1:0]  s;
        logic [LW-1:0] d_e;
        logic          tmo, sh_e, wb_e;
        int            maxd, en, n;
        s    = N'(1) << r;
        maxd = 0;
        foreach (dly[i]) if (i != r && dly[i] > maxd) maxd = dly[i];
        tmo  = maxd + 1 > TO;
        en   = tmo ? TO : maxd + 1;
        sh_e = 1'b0;
        wb_e = 1'b0;
        d_e  = mdat;
        foreach (dly[i]) if (i != r && dly[i] < en) begin
            sh_e = sh_e | shr[i] | drt[i];
            if (drt[i]) begin
                wb_e = 1'b1;
                d_e  = dat[i];
            end
        end
        sh_e = sh_e && c == 2'd0;
        if (c == 2'd2) begin
            wb_e = 1'b0;
            d_e  = '0;
        end
        for (int i = 0; i < N; i++) begin
            req_cmd[i*2 +: 2]   = 2'($urandom_range(0, 2));
            req_addr[i*AW +: AW] = $urandom;
        end
        req_cmd[r*2 +: 2]   = c;
        req_addr[r*AW +: AW] = a;
        gnt = s;
        tick;
        gnt = '0;
        chk("busy_snoop", bus_busy, 1);
        chk("snoop_valid", snoop_valid, 1);
        chk("snoop_src", snoop_src, s);
        chk("snoop_cmd", snoop_cmd, c);
        chk("snoop_addr", snoop_addr, a);
        n = 0;
        while (snoop_valid === 1'b1 && n < 300) begin
            for (int i = 0; i < N; i++) snoop_data[i*LW +: LW] = rnd_line();
            snoop_ack    = '0;
            snoop_shared = N'($urandom);
            snoop_dirty  = N'($urandom);
            for (int i = 0; i < N; i++)
                if (i == r ? $urandom_range(0, 1) == 1 : dly[i] == n) begin
                    snoop_ack[i]             = 1'b1;
                    snoop_shared[i]          = shr[i];
                    snoop_dirty[i]           = drt[i];
                    snoop_data[i*LW +: LW]   = dat[i];
                end
            gnt       = rnd_gnt();
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = rnd_line();
            tick;
            n++;
        end
        snoop_ack    = '0;
        snoop_shared = '0;
        snoop_dirty  = '0;
        mem_ready    = 1'b0;
        chk("snoop_cycles", n, en);
        chk("err_timeout", err_timeout, tmo);
        chk("busy_after_snoop", bus_busy, 1);
        if (c == 2'd2) begin
            chk("upgr_no_mem", mem_req, 0);
            chk("upgr_resp_valid", resp_valid, s);
            chk("upgr_resp_shared", resp_shared, 0);
            chk("upgr_resp_data", resp_data, 0);
        end else begin
            chk("mem_req", mem_req, 1);
            chk("mem_we", mem_we, wb_e);
            chk("mem_addr", mem_addr, a);
            if (wb_e) chk("mem_wdata", mem_wdata, d_e);
            for (int k = 0; k < mlat; k++) begin
                gnt = rnd_gnt();
                tick;
                chk("mem_hold", {mem_req, mem_we, mem_addr}, {1'b1, wb_e, a});
            end
            mem_ready = 1'b1;
            mem_rdata = mdat;
            gnt       = '0;
            tick;
            mem_ready = 1'b0;
            mem_rdata = rnd_line();
            chk("resp_valid", resp_valid, s);
            chk("resp_shared", resp_shared, sh_e);
            chk("resp_data", resp_data, d_e);
            chk("mem_req_drop", mem_req, 0);
            chk("busy_resp", bus_busy, 1);
        end
        gnt = '0;
        tick;
        chk("resp_pulse_end", resp_valid, 0);
        chk("busy_idle", bus_busy, 0);
    endtask

    initial begin
        defaults();
        tick;
        tick;
        chk("rst_busy", bus_busy, 0);
        chk("rst_snoop_valid", snoop_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_src", snoop_src, 0);
        chk("rst_err", err_timeout, 0);
        rst = 1'b1;
        tick;

        defaults();
        mdat = {8{32'hA5A5_0001}};
        run_txn(1, 2'd0, 32'h100);

        defaults();
        drt    = 4'b1000;
        dat[3] = {8{32'hB0B0_0003}};
        run_txn(1, 2'd0, 32'h140);

        defaults();
        shr = 4'b0110;
        run_txn(0, 2'd2, 32'h180);

        defaults();
        dly[2] = 3;
        dly[3] = 1;
        shr    = 4'b0100;
        mlat   = 2;
        run_txn(0, 2'd0, 32'h1C0);

        defaults();
        shr = 4'b1111;
        run_txn(3, 2'd1, 32'h200);

`ifdef SNOOP_TIMEOUT_EN
        defaults();
        dly[2] = 1000;
        shr    = 4'b0100;
        run_txn(0, 2'd0, 32'h240);
`else
        defaults();
        dly[0] = 70;
        shr    = 4'b0001;
        run_txn(2, 2'd0, 32'h240);
`endif

        defaults();
        req_cmd  = 8'b0000_0100;
        req_addr = '0;
        req_addr[AW +: AW] = 32'h55;
        gnt = 4'b0010;
        tick;
        gnt       = '0;
        snoop_ack = 4'b1101;
        tick;
        snoop_ack = '0;
        chk("pre_rst_mem_req", mem_req, 1);
        tick;
        #2 rst = 1'b0;
        #1;
        chk("midrst_busy", bus_busy, 0);
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_snoop_src", snoop_src, 0);
        chk("midrst_mem_addr", mem_addr, 0);
        mem_ready = 1'b1;
        tick;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("postrst_no_resp", {resp_valid, bus_busy}, 0);
        end
        mem_ready = 1'b0;

        for (int t = 0; t < 40; t++) begin
            defaults();
            foreach (dly[i]) dly[i] = $urandom_range(0, 4);
            shr  = N'($urandom);
            drt  = $urandom_range(0, 1) == 1 ? N'(1) << $urandom_range(0, N - 1) : '0;
            mlat = $urandom_range(0, 3);
            run_txn($urandom_range(0, N - 1), 2'($urandom_range(0, 2)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/snoop_bus_ctrl.md
Name: snoop_bus_ctrl

Overview:
- Coherence bus controller directly downstream of the round-robin bus arbiter.
- Accepts the winning cache's one-hot grant and latches that cache's bus transaction (BusRd / BusRdX / BusUpgr).
- Broadcasts the transaction as a snoop to all other caches and collects their acks/shared/dirty replies.
- Sources the line from the dirty owner (with memory writeback) or from memory, then returns it to the requester.
- Drives bus_busy back into the arbiter's busy input, so no new grant is issued while a transaction is in flight.

Parameters:
- NUM_CPUS, 4, number of caches on the bus (from package types).
- ADDR_W, 32, line address width.
- LINE_W, 256, cache line width in bits.
- TIMEOUT_CYC, 64, snoop watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-low.
- gnt  in  NUM_CPUS  one-hot grant from arbiter.
- req_cmd  in  NUM_CPUS*2  per-CPU bus_cmd_t.
- req_addr  in  NUM_CPUS*ADDR_W  per-CPU line address.
- bus_busy  out  1  transaction in flight; feeds arbiter busy.
- snoop_valid  out  1  snoop broadcast active.
- snoop_cmd  out  2  latched bus_cmd_t.
- snoop_addr  out  ADDR_W  latched address.
- snoop_src  out  NUM_CPUS  one-hot requester; that cache ignores the snoop.
- snoop_ack  in  NUM_CPUS  per-cache snoop done.
- snoop_shared  in  NUM_CPUS  cache holds the line.
- snoop_dirty  in  NUM_CPUS  cache holds the line M.
- snoop_data  in  NUM_CPUS*LINE_W  per-cache flush data.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = writeback.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  LINE_W  writeback data.
- mem_ready  in  1  memory completes (read data valid when mem_we=0).
- mem_rdata  in  LINE_W  memory read data.
- resp_valid  out  NUM_CPUS  one-cycle completion pulse to requester.
- resp_shared  out  1  requester installs in S (1) or E/M (0).
- resp_data  out  LINE_W  line data.
- err_timeout  out  1  watchdog pulse.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all outputs 0; latched src/cmd/addr/data cleared.
  - A reset mid-transaction abandons it with no response.
- IDLE:
  - bus_busy=0.
  - If gnt!=0, latch src=gnt, cmd=req_cmd[src], addr=req_addr[src], clear ack mask, then go to SNOOP.
  - A grant is consumed in exactly one cycle; gnt is ignored in all other states.
  - gnt with more than one bit set is illegal (assertion); the lowest set bit is used.
- bus_busy=1 in every state except IDLE.
- SNOOP:
  - snoop_valid=1.
  - Ack mask accumulates snoop_ack & ~src.
  - Shared/dirty are captured in the cycle each ack arrives.
  - Complete when the mask equals ~src. With NUM_CPUS=1 this completes in the first SNOOP cycle.
  - Exit on completion:
    - cmd=BusUpgr: go to RESP (no data).
    - Any dirty: latch the owner's snoop_data (lowest index if several; multiple dirty is an assertion error), then go to MEM_WB.
    - Otherwise: go to MEM_RD.
- MEM_WB:
  - mem_req=1, mem_we=1, mem_addr=addr, mem_wdata=owner data; all held stable until mem_ready.
  - On mem_ready, go to RESP with data=owner data.
- MEM_RD:
  - mem_req=1, mem_we=0, held until mem_ready.
  - On mem_ready, latch mem_rdata and go to RESP.
- RESP:
  - resp_valid=src for one cycle; resp_data=latched data.
  - resp_shared = (cmd==BusRd) & any shared-or-dirty; 0 for BusRdX and BusUpgr.
  - Go to IDLE.
- Latency: grant cycle T, SNOOP at T+1. With acks at T+1 and mem_ready on the first cycle of MEM_RD (T+2), resp_valid is at T+3 and bus_busy falls at T+4.
- mem_ready is ignored when mem_req=0.

Optional Feature:
- Macro: SNOOP_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in SNOOP.
  - When TIMEOUT_CYC cycles pass without completion, missing acks are treated as clean/not-shared.
  - err_timeout pulses for 1 cycle and the FSM exits SNOOP as if complete.
- When undefined: no counter; err_timeout is tied 0; SNOOP waits indefinitely.

Decomposition:
- Package types:
  - NUM_CPUS.
  - bus_cmd_t enum {BUS_RD=0, BUS_RDX=1, BUS_UPGR=2}.
  - bus_state_t enum {IDLE, SNOOP, MEM_WB, MEM_RD, RESP}.
- Sub-module snoop_collector: ack mask, shared/dirty OR, owner one-hot, data mux.

Test Plan:
- BusRd, no sharers: gnt=0010, addr=0x100, acks from 0/2/3 at T+1 with shared=0; mem_ready at T+2, rdata=A → resp_valid=0010 at T+3, resp_shared=0, resp_data=A, bus_busy high T+1..T+3.
- BusRd, CPU3 dirty: snoop_dirty=1000, data=B → MEM_WB with mem_we=1, mem_wdata=B → resp_data=B, resp_shared=1.
- BusUpgr from CPU0: all acks arrive → no mem_req; resp_valid=0001 one cycle after snoop completes.
- Staggered acks: CPU1 acks at T+1, CPU2 at T+4, CPU3 at T+2 → snoop_valid held until T+4; gnt pulses mid-transaction are ignored.
- Reset mid-MEM_RD → all outputs 0 immediately, state IDLE, no resp_valid.
- SNOOP_TIMEOUT_EN: CPU2 never acks → err_timeout pulses at SNOOP cycle 64, then memory read proceeds.
